// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped direction-and-target predictor sitting between IF (lookup) and
// EX (resolve). The fetch-side lookup is purely combinational. The resolve side
// trains the table at the clock edge and raises a registered one-cycle redirect
// when the carried-down prediction disagrees with the comparator outcome.
//
// Ports
//   clk, reset                       rising-edge clock, synchronous active-high reset
//   fetch_valid, fetch_pc            lookup request
//   pred_taken, pred_target          combinational prediction for fetch_pc
//   res_valid, res_is_branch         resolve qualifiers from EX
//   res_pc, res_taken, res_target    resolved branch PC, outcome and target
//   res_pred_taken, res_pred_target  prediction that travelled with the branch
//   mispredict, redirect_pc          registered redirect pulse and correct next PC
//   branch_count, mispredict_count   saturating performance counters
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 6,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_valid,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             res_valid,
    input  logic             res_is_branch,
    input  logic [XLEN-1:0]  res_pc,
    input  logic             res_taken,
    input  logic [XLEN-1:0]  res_target,
    input  logic             res_pred_taken,
    input  logic [XLEN-1:0]  res_pred_target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = XLEN - INDEX_BITS - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [1:0]       ctr;
    } entry_t;

    entry_t bht [ENTRIES];

    // ---------------------------------------------------------------- lookup
    logic [INDEX_BITS-1:0] fetch_idx;
    logic [TAG_W-1:0]      fetch_tag;
    entry_t                fetch_entry;
    logic                  fetch_hit;

    assign fetch_idx   = fetch_pc[INDEX_BITS+1:2];
    assign fetch_tag   = fetch_pc[XLEN-1:INDEX_BITS+2];
    assign fetch_entry = bht[fetch_idx];
    assign fetch_hit   = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
    assign pred_taken  = fetch_valid && fetch_hit && fetch_entry.ctr[1];
    assign pred_target = pred_taken ? fetch_entry.target : fetch_pc + XLEN'(4);

    // --------------------------------------------------------------- resolve
    logic [INDEX_BITS-1:0] res_idx;
    logic [TAG_W-1:0]      res_tag;
    entry_t                res_entry;
    logic                  res_hit;
    logic                  res_update;
    logic                  res_wrong;
    logic [XLEN-1:0]       res_next_pc;
    logic [1:0]            res_ctr_next;

    assign res_idx     = res_pc[INDEX_BITS+1:2];
    assign res_tag     = res_pc[XLEN-1:INDEX_BITS+2];
    assign res_entry   = bht[res_idx];
    assign res_hit     = res_entry.valid && (res_entry.tag == res_tag);
    assign res_update  = res_valid && res_is_branch;
    // A correct direction with a stale target still sends fetch the wrong way.
    assign res_wrong   = (res_taken != res_pred_taken) ||
                         (res_taken && res_pred_taken && (res_target != res_pred_target));
    assign res_next_pc = res_taken ? res_target : res_pc + XLEN'(4);

    // NOTE: every variable driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        res_ctr_next = res_entry.ctr;
        if (res_taken) begin
            if (res_entry.ctr != 2'b11) res_ctr_next = res_entry.ctr + 2'b01;
        end else begin
            if (res_entry.ctr != 2'b00) res_ctr_next = res_entry.ctr - 2'b01;
        end
    end

    // Table training. A lookup in the same cycle still sees the old contents
    // because the write lands at the edge.
    // NOTE: only valid and ctr are reset; tag and target are don't-care while
    // valid=0, so leaving them unreset keeps the array free of a reset fan-out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i].valid <= 1'b0;
                bht[i].ctr   <= 2'b01;
            end
        end else if (res_update) begin
            if (res_hit) begin
                bht[res_idx].ctr <= res_ctr_next;
                if (res_taken) bht[res_idx].target <= res_target;
            end else if (res_taken) begin
                bht[res_idx] <= entry_t'{valid: 1'b1, tag: res_tag,
                                         target: res_target, ctr: 2'b10};
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict       <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            mispredict <= res_update && res_wrong;
            if (res_update && res_wrong) begin
                redirect_pc <= res_next_pc;
                if (mispredict_count != '1) mispredict_count <= mispredict_count + 1'b1;
            end
            if (res_update && branch_count != '1) branch_count <= branch_count + 1'b1;
        end
    end

    // Word-aligned PCs: the low two bits never reach the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], res_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic        res_is_branch;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_predictor #(.XLEN(32), .INDEX_BITS(6), .CNT_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_valid      (fetch_valid),
        .fetch_pc         (fetch_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .res_valid        (res_valid),
        .res_is_branch    (res_is_branch),
        .res_pc           (res_pc),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .res_pred_taken   (res_pred_taken),
        .res_pred_target  (res_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic        rv;
        logic        rb;
        logic [31:0] rpc;
        logic        rt;
        logic [31:0] rtgt;
        logic        rpt;
        logic [31:0] rptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mis;
        logic [31:0] e_redir;
        logic [15:0] e_bc;
        logic [15:0] e_mc;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    function automatic vec_t v(
        input logic fv, input logic [31:0] fpc,
        input logic rv, input logic rb, input logic [31:0] rpc,
        input logic rt, input logic [31:0] rtgt,
        input logic rpt, input logic [31:0] rptgt,
        input logic e_pt, input logic [31:0] e_ptgt,
        input logic e_mis, input logic [31:0] e_redir,
        input logic [15:0] e_bc, input logic [15:0] e_mc);
        vec_t r;
        r.fv = fv; r.fpc = fpc; r.rv = rv; r.rb = rb; r.rpc = rpc;
        r.rt = rt; r.rtgt = rtgt; r.rpt = rpt; r.rptgt = rptgt;
        r.e_pt = e_pt; r.e_ptgt = e_ptgt; r.e_mis = e_mis; r.e_redir = e_redir;
        r.e_bc = e_bc; r.e_mc = e_mc;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_valid     = 1'b0;
        fetch_pc        = 32'h0;
        res_valid       = 1'b0;
        res_is_branch   = 1'b0;
        res_pc          = 32'h0;
        res_taken       = 1'b0;
        res_target      = 32'h0;
        res_pred_taken  = 1'b0;
        res_pred_target = 32'h0;
    endtask

    initial begin
        //                fv  fpc           rv rb rpc           rt rtgt          rpt rptgt         e_pt e_ptgt       e_mis e_redir      bc  mc
        // Cold lookup misses.
        vecs[0]  = v(1, 32'h100,      0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h104,     0, 32'h0,   0, 0);
        // Taken, predicted not-taken: allocate with ctr=10.
        vecs[1]  = v(0, 32'h100,      1, 1, 32'h100,      1, 32'h80,  0, 32'h104, 0, 32'h104,     1, 32'h80,  1, 1);
        // Same-cycle lookup sees old entry (10 -> taken); NT resolve trains to 01.
        vecs[2]  = v(1, 32'h100,      1, 1, 32'h100,      0, 32'h80,  1, 32'h80,  1, 32'h80,      1, 32'h104, 2, 2);
        vecs[3]  = v(1, 32'h100,      1, 1, 32'h100,      0, 32'h80,  0, 32'h104, 0, 32'h104,     0, 32'h0,   3, 2);
        vecs[4]  = v(1, 32'h100,      1, 1, 32'h100,      0, 32'h80,  0, 32'h104, 0, 32'h104,     0, 32'h0,   4, 2);
        // ctr saturated at 00 -> still not taken.
        vecs[5]  = v(1, 32'h100,      1, 1, 32'h100,      0, 32'h80,  0, 32'h104, 0, 32'h104,     0, 32'h0,   5, 2);
        // Back-to-back mispredicts climbing 00 -> 01 -> 10, then target change.
        vecs[6]  = v(1, 32'h100,      1, 1, 32'h100,      1, 32'h80,  0, 32'h104, 0, 32'h104,     1, 32'h80,  6, 3);
        vecs[7]  = v(1, 32'h100,      1, 1, 32'h100,      1, 32'h80,  0, 32'h104, 0, 32'h104,     1, 32'h80,  7, 4);
        vecs[8]  = v(1, 32'h100,      1, 1, 32'h100,      1, 32'h90,  1, 32'h80,  1, 32'h80,      1, 32'h90,  8, 5);
        // Correct taken prediction; ctr saturates at 11.
        vecs[9]  = v(1, 32'h100,      1, 1, 32'h100,      1, 32'h90,  1, 32'h90,  1, 32'h90,      0, 32'h0,   9, 5);
        vecs[10] = v(1, 32'h100,      1, 1, 32'h100,      0, 32'h90,  1, 32'h90,  1, 32'h90,      1, 32'h104, 10, 6);
        // ctr now 10; alias at 0x200 replaces index 0.
        vecs[11] = v(1, 32'h100,      1, 1, 32'h200,      1, 32'h300, 0, 32'h204, 1, 32'h90,      1, 32'h300, 11, 7);
        vecs[12] = v(1, 32'h100,      0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h104,     0, 32'h0,   11, 7);
        // Non-branch resolve with a mismatching outcome is ignored.
        vecs[13] = v(1, 32'h200,      1, 0, 32'h200,      1, 32'h400, 0, 32'h204, 1, 32'h300,     0, 32'h0,   11, 7);
        // Not-taken mispredict at the top of the address space wraps to 0.
        vecs[14] = v(1, 32'h200,      1, 1, 32'hFFFFFFFC, 0, 32'h10,  1, 32'h10,  1, 32'h300,     1, 32'h0,   12, 8);
        // Miss + not taken did not allocate.
        vecs[15] = v(1, 32'hFFFFFFFC, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h0,       0, 32'h0,   12, 8);
        // fetch_valid=0 suppresses a hit.
        vecs[16] = v(0, 32'h200,      0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h204,     0, 32'h0,   12, 8);

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("reset mispredict", {31'b0, mispredict}, 32'h0);
        check("reset redirect_pc", redirect_pc, 32'h0);
        check("reset branch_count", {16'b0, branch_count}, 32'h0);
        check("reset mispredict_count", {16'b0, mispredict_count}, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            fetch_valid     = vecs[i].fv;
            fetch_pc        = vecs[i].fpc;
            res_valid       = vecs[i].rv;
            res_is_branch   = vecs[i].rb;
            res_pc          = vecs[i].rpc;
            res_taken       = vecs[i].rt;
            res_target      = vecs[i].rtgt;
            res_pred_taken  = vecs[i].rpt;
            res_pred_target = vecs[i].rptgt;
            #2;
            check($sformatf("v%0d pred_taken", i), {31'b0, pred_taken}, {31'b0, vecs[i].e_pt});
            check($sformatf("v%0d pred_target", i), pred_target, vecs[i].e_ptgt);
            tick();
            check($sformatf("v%0d mispredict", i), {31'b0, mispredict}, {31'b0, vecs[i].e_mis});
            if (vecs[i].e_mis)
                check($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].e_redir);
            check($sformatf("v%0d branch_count", i), {16'b0, branch_count}, {16'b0, vecs[i].e_bc});
            check($sformatf("v%0d mispredict_count", i), {16'b0, mispredict_count}, {16'b0, vecs[i].e_mc});
        end

        // Reset asserted during a mispredicting resolve: reset wins.
        idle_inputs();
        tick();
        reset           = 1'b1;
        res_valid       = 1'b1;
        res_is_branch   = 1'b1;
        res_pc          = 32'h200;
        res_taken       = 1'b1;
        res_target      = 32'h500;
        res_pred_taken  = 1'b0;
        res_pred_target = 32'h204;
        tick();
        check("rst-resolve mispredict", {31'b0, mispredict}, 32'h0);
        check("rst-resolve redirect_pc", redirect_pc, 32'h0);
        check("rst-resolve branch_count", {16'b0, branch_count}, 32'h0);
        check("rst-resolve mispredict_count", {16'b0, mispredict_count}, 32'h0);
        idle_inputs();
        reset = 1'b0;
        tick();
        check("post-reset mispredict", {31'b0, mispredict}, 32'h0);
        fetch_valid = 1'b1;
        fetch_pc    = 32'h200;
        #2;
        check("post-reset pred_taken", {31'b0, pred_taken}, 32'h0);
        check("post-reset pred_target", pred_target, 32'h204);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
